// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_stage
// Purpose  : Sequential instruction fetch with a credit-limited prefetch queue
//            feeding decode; flushF redirects and discards in-flight responses.
// Options  : FETCH_PERF_EN adds perf_flushes / perf_bubbles counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flushF,
    input  logic [ADDR_W-1:0]  branchTarget,
    input  logic               stallF,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instrD,
    output logic [ADDR_W-1:0]  pcD,
    output logic               validD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_flushes,
    output logic [31:0]        perf_bubbles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  pc;

    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0]  q_pc    [DEPTH];
    logic [PTR_W-1:0]   q_rd;
    logic [PTR_W-1:0]   q_wr;
    logic [CNT_W-1:0]   q_cnt;

    logic [ADDR_W-1:0]  tag_mem [DEPTH];
    logic [PTR_W-1:0]   tag_rd;
    logic [PTR_W-1:0]   tag_wr;

    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop;

    logic [CNT_W:0]     credit_sum;
    logic [CNT_W-1:0]   live_outstanding;
    logic               granted;
    logic               rsp_acc;
    logic               push;
    logic               pop;

    // Queued entries plus requests in flight may never exceed the queue size,
    // so every kept response is guaranteed a free slot.
    assign credit_sum       = {1'b0, q_cnt} + {1'b0, outstanding};
    assign imem_req         = !rst && !flushF && (credit_sum < (CNT_W+1)'(DEPTH));
    assign imem_addr        = pc;
    assign granted          = imem_req && imem_gnt;
    assign rsp_acc          = imem_rvalid && (outstanding != '0);
    assign live_outstanding = outstanding + CNT_W'(granted) - CNT_W'(rsp_acc);
    assign push             = rsp_acc && !flushF && (drop == '0);

    assign validD = (q_cnt != '0) && !flushF;
    assign pop    = validD && !stallF;
    assign instrD = q_instr[q_rd];
    assign pcD    = q_pc[q_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            outstanding <= live_outstanding;
            if (flushF) begin
                pc     <= branchTarget;
                tag_rd <= '0;
                tag_wr <= '0;
                drop   <= live_outstanding;
            end else begin
                if (granted) begin
                    pc              <= pc + ADDR_W'(PC_INC);
                    tag_mem[tag_wr] <= pc;
                    tag_wr          <= tag_wr + PTR_W'(1);
                end
                if (rsp_acc && (drop != '0)) begin
                    drop <= drop - CNT_W'(1);
                end
                if (push) begin
                    tag_rd <= tag_rd + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_rd  <= '0;
            q_wr  <= '0;
            q_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (flushF) begin
            q_rd  <= '0;
            q_wr  <= '0;
            q_cnt <= '0;
        end else begin
            if (push) begin
                q_instr[q_wr] <= imem_rdata;
                q_pc[q_wr]    <= tag_mem[tag_rd];
                q_wr          <= q_wr + PTR_W'(1);
            end
            if (pop) begin
                q_rd <= q_rd + PTR_W'(1);
            end
            if (push && !pop) begin
                q_cnt <= q_cnt + CNT_W'(1);
            end else if (!push && pop) begin
                q_cnt <= q_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (q_cnt == CNT_W'(DEPTH))));
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_flushes <= '0;
            perf_bubbles <= '0;
        end else begin
            if (flushF && (perf_flushes != '1)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
            if (!validD && !stallF && (perf_bubbles != '1)) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_stage.sv
`default_nettype none
// Testbench for fetch_queue_stage: directed scenarios with a latency-programmable
// in-order memory model and a scoreboard of expected decode-side PCs.
module tb_fetch_queue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flushF;
    logic        stallF;
    logic [31:0] branchTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        validD;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_flushes;
    logic [31:0] perf_bubbles;
`endif

    always #5 clk = ~clk;

    fetch_queue_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flushF       (flushF),
        .branchTarget (branchTarget),
        .stallF       (stallF),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instrD       (instrD),
        .pcD          (pcD),
        .validD       (validD)
`ifdef FETCH_PERF_EN
        ,
        .perf_flushes (perf_flushes),
        .perf_bubbles (perf_bubbles)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;
    bit gnt_en   = 1'b1;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } req_t;

    req_t        pend[$];
    logic [31:0] sb[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // In-order memory: grants when enabled, answers each grant after 'lat' cycles.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
            if (imem_req && imem_gnt) pend.push_back('{due: cyc + lat, addr: imem_addr});
            @(posedge clk);
            #2;
            imem_gnt = gnt_en;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(pend[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    // Decode-side monitor: every accepted instruction must match the scoreboard head.
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            if (!rst && validD && !stallF) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop: actual pcD=%h expected no instruction (cycle %0d)", pcD, cyc);
                end else begin
                    exp_pc = sb.pop_front();
                    chk("pcD", pcD, exp_pc);
                    chk("instrD", instrD, instr_of(exp_pc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        flushF = 1'b0;
        stallF = 1'b0;
        pend.delete();
        repeat (2) next_cycle();
        sample();
        chk("rst_validD", 32'(validD), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pcD", pcD, 32'd0);
        chk("rst_instrD", instrD, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
    endtask

    task automatic drain_and_reset();
        for (int n = 0; n < 60; n++) begin
            next_cycle();
            if (sb.size() == 0) break;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        sb.delete();
        reset_dut();
    endtask

    task automatic release_rst();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int nreq;
        rst          = 1'b1;
        flushF       = 1'b0;
        stallF       = 1'b0;
        branchTarget = '0;
        reset_dut();

        // 1: streaming fetch, latency 1
        lat = 1;
        gnt_en = 1'b1;
        sb.push_back(32'h0);  sb.push_back(32'h4);
        sb.push_back(32'h8);  sb.push_back(32'hC);
        release_rst();
        sample();
        chk("t1_validD_c0", 32'(validD), 32'd0);
        chk("t1_req_c0", 32'(imem_req), 32'd1);
        chk("t1_addr_c0", imem_addr, 32'h0);
        next_cycle();
        sample();
        chk("t1_validD_c1", 32'(validD), 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            sample();
            chk("t1_validD_stream", 32'(validD), 32'd1);
        end
        drain_and_reset();

        // 2: decode stalled, queue fills to DEPTH, then drains without gaps
        stallF = 1'b1;
        nreq = 0;
        release_rst();
        sample();
        if (imem_req && imem_gnt) nreq++;
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            sample();
            if (imem_req && imem_gnt) nreq++;
        end
        chk("t2_req_count", 32'(nreq), 32'd4);
        chk("t2_req_idle", 32'(imem_req), 32'd0);
        chk("t2_pcD_hold", pcD, 32'h0);
        chk("t2_validD_hold", 32'(validD), 32'd1);
        for (int i = 0; i < 5; i++) sb.push_back(32'(4 * i));
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            stallF = 1'b0;
            sample();
            chk("t2_validD_drain", 32'(validD), 32'd1);
        end
        drain_and_reset();

        // 3: flush with three requests outstanding, latency 3
        lat = 3;
        sb.push_back(32'h100); sb.push_back(32'h104); sb.push_back(32'h108);
        release_rst();
        repeat (2) next_cycle();
        next_cycle();
        flushF = 1'b1;
        branchTarget = 32'h100;
        sample();
        chk("t3_validD_flush", 32'(validD), 32'd0);
        chk("t3_req_flush", 32'(imem_req), 32'd0);
        next_cycle();
        flushF = 1'b0;
        sample();
        chk("t3_addr_redirect", imem_addr, 32'h100);
        chk("t3_req_redirect", 32'(imem_req), 32'd1);
        drain_and_reset();

        // 4: flush coinciding with gnt and rvalid, queue already holding PC 0
        lat = 2;
        sb.push_back(32'h200); sb.push_back(32'h204); sb.push_back(32'h208);
        release_rst();
        repeat (2) next_cycle();
        next_cycle();
        flushF = 1'b1;
        branchTarget = 32'h200;
        sample();
        chk("t4_validD_flush", 32'(validD), 32'd0);
        chk("t4_req_flush", 32'(imem_req), 32'd0);
        next_cycle();
        flushF = 1'b0;
        sample();
        chk("t4_addr_redirect", imem_addr, 32'h200);
        drain_and_reset();

        // 5: back-to-back flushes, second target wins
        lat = 2;
        sb.push_back(32'h300); sb.push_back(32'h304);
        release_rst();
        repeat (2) next_cycle();
        next_cycle();
        flushF = 1'b1;
        branchTarget = 32'h200;
        next_cycle();
        branchTarget = 32'h300;
        sample();
        chk("t5_validD_flush2", 32'(validD), 32'd0);
        next_cycle();
        flushF = 1'b0;
        sample();
        chk("t5_addr_redirect", imem_addr, 32'h300);
`ifdef FETCH_PERF_EN
        chk("t5_perf_flushes", perf_flushes, 32'd2);
`endif
        drain_and_reset();

        // 6: PC wraps past the top of the address space
        lat = 1;
        sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0); sb.push_back(32'h4);
        release_rst();
        flushF = 1'b1;
        branchTarget = 32'hFFFF_FFFC;
        sample();
        chk("t6_req_flush", 32'(imem_req), 32'd0);
        next_cycle();
        flushF = 1'b0;
        sample();
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        next_cycle();
        sample();
        chk("t6_addr_wrap", imem_addr, 32'h0);
        drain_and_reset();

        // 7: reset with two queued and two outstanding; late responses ignored
        lat = 3;
        stallF = 1'b1;
        release_rst();
        repeat (4) next_cycle();
        sample();
        chk("t7_validD_pre", 32'(validD), 32'd1);
        next_cycle();
        rst = 1'b1;
        sample();
        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
        next_cycle();
        rst = 1'b0;
        stallF = 1'b0;
        sample();
        chk("t7_validD_post", 32'(validD), 32'd0);
        chk("t7_addr_post", imem_addr, 32'h0);
        chk("t7_pcD_post", pcD, 32'h0);
`ifdef FETCH_PERF_EN
        chk("t7_perf_flushes", perf_flushes, 32'd0);
        chk("t7_perf_bubbles", perf_bubbles, 32'd0);
`endif
        drain_and_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
